// File: rtl/axi_wr_pkg.sv
// Shared encodings and state type for the AXI4 write burst engine.
// Burst types, response codes and the FSM state enum.
package axi_wr_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } wr_state_e;

endpackage

// File: rtl/axi_master_write_burst_engine.sv
// AXI4 write master: one command -> AW, then W beats passed straight
// through from the decoder; B responses are returned as rsp pulses.
module axi_master_write_burst_engine
  import axi_wr_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int ID_W    = 4,
  parameter int MAX_OUT = 4,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              AClk,
  input  logic              ARst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ID_W-1:0]   cmd_id,
  input  logic [7:0]        cmd_len,
  input  logic [1:0]        cmd_burst,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  input  logic [STRB_W-1:0] wd_strb,
  output logic [ID_W-1:0]   AWID,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [7:0]        AWLEN,
  output logic [2:0]        AWSIZE,
  output logic [1:0]        AWBURST,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic [STRB_W-1:0] WSTRB,
  output logic              WLAST,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [ID_W-1:0]   BID,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output logic              rsp_valid,
  output logic [ID_W-1:0]   rsp_id,
  output logic [1:0]        rsp_resp
);

  localparam int OW = $clog2(MAX_OUT + 1);

  wr_state_e         state;
  logic [8:0]        beats;
  logic [OW-1:0]     outst;
  logic              aw_hs;
  logic              w_hs;
  logic              b_hs;
  logic              in_data;

  assign in_data = (state == ST_DATA);
  assign aw_hs   = AWVALID && AWREADY;
  assign w_hs    = WVALID && WREADY;
  assign b_hs    = BVALID && BREADY;

  assign cmd_ready = !ARst && (state == ST_IDLE)
                   && (outst < OW'(MAX_OUT));
  assign BREADY    = (outst != '0);

  // W channel is a zero-latency pass-through, gated to the data phase
  assign WVALID   = in_data && wd_valid;
  assign wd_ready = in_data && WREADY;
  assign WDATA    = in_data ? wd_data : '0;
  assign WSTRB    = in_data ? wd_strb : '0;
  assign WLAST    = in_data && (beats == 9'd1);
  assign AWSIZE   = 3'($clog2(STRB_W));

  always_ff @(posedge AClk) begin
    if (ARst) begin
      state     <= ST_IDLE;
      beats     <= '0;
      outst     <= '0;
      AWID      <= '0;
      AWADDR    <= '0;
      AWLEN     <= '0;
      AWBURST   <= '0;
      AWVALID   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_resp  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            AWID    <= cmd_id;
            AWADDR  <= cmd_addr;
            AWLEN   <= cmd_len;
            AWBURST <= cmd_burst;
            AWVALID <= 1'b1;
            beats   <= {1'b0, cmd_len} + 9'd1;
            state   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (AWREADY) begin
            AWVALID <= 1'b0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_hs) begin
            beats <= beats - 9'd1;
            if (beats == 9'd1)
              state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // simultaneous AW and B handshakes cancel out
      unique case ({aw_hs, b_hs})
        2'b10:   outst <= outst + OW'(1);
        2'b01:   outst <= outst - OW'(1);
        default: outst <= outst;
      endcase

      rsp_valid <= b_hs;
      if (b_hs) begin
        rsp_id   <= BID;
        rsp_resp <= BRESP;
      end
    end
  end

endmodule

// File: tb/tb_axi_master_write_burst_engine.sv
// Directed bench for the write burst engine: table of single bursts
// plus hand sequences for AW stall, MAX_OUT, AW/B overlap and reset.
module tb_axi_master_write_burst_engine;

  logic        AClk = 1'b0;
  logic        ARst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_id;
  logic [7:0]  cmd_len;
  logic [1:0]  cmd_burst;
  logic        wd_valid;
  logic        wd_ready;
  logic [63:0] wd_data;
  logic [7:0]  wd_strb;
  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic        rsp_valid;
  logic [3:0]  rsp_id;
  logic [1:0]  rsp_resp;

  int n_checks = 0;
  int n_fail   = 0;

  axi_master_write_burst_engine #(
    .ADDR_W (32),
    .DATA_W (64),
    .ID_W   (4),
    .MAX_OUT(2)
  ) dut (
    .AClk     (AClk),
    .ARst     (ARst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr (cmd_addr),
    .cmd_id   (cmd_id),
    .cmd_len  (cmd_len),
    .cmd_burst(cmd_burst),
    .wd_valid (wd_valid),
    .wd_ready (wd_ready),
    .wd_data  (wd_data),
    .wd_strb  (wd_strb),
    .AWID     (AWID),
    .AWADDR   (AWADDR),
    .AWLEN    (AWLEN),
    .AWSIZE   (AWSIZE),
    .AWBURST  (AWBURST),
    .AWVALID  (AWVALID),
    .AWREADY  (AWREADY),
    .WDATA    (WDATA),
    .WSTRB    (WSTRB),
    .WLAST    (WLAST),
    .WVALID   (WVALID),
    .WREADY   (WREADY),
    .BID      (BID),
    .BRESP    (BRESP),
    .BVALID   (BVALID),
    .BREADY   (BREADY),
    .rsp_valid(rsp_valid),
    .rsp_id   (rsp_id),
    .rsp_resp (rsp_resp)
  );

  always #5 AClk = ~AClk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [1:0]  bresp;
    bit          stall;
    int          exp_beats;
  } vec_t;

  task automatic tick();
    @(negedge AClk);
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, " AWVALID"}, 64'(AWVALID), 64'd0);
    chk({tag, " WVALID"}, 64'(WVALID), 64'd0);
    chk({tag, " WLAST"}, 64'(WLAST), 64'd0);
    chk({tag, " wd_ready"}, 64'(wd_ready), 64'd0);
    chk({tag, " BREADY"}, 64'(BREADY), 64'd0);
    chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, " AWADDR"}, 64'(AWADDR), 64'd0);
    chk({tag, " AWID"}, 64'(AWID), 64'd0);
    chk({tag, " AWLEN"}, 64'(AWLEN), 64'd0);
    chk({tag, " WDATA"}, WDATA, 64'd0);
    chk({tag, " WSTRB"}, 64'(WSTRB), 64'd0);
  endtask

  task automatic issue_cmd(input logic [31:0] a, input logic [3:0] id,
                           input logic [7:0] len, input logic [1:0] b);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_id    = id;
    cmd_len   = len;
    cmd_burst = b;
    #1 chk("cmd_ready idle", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic [3:0] id,
                            input logic [7:0] len, input logic [1:0] b,
                            input int stall);
    AWREADY = 1'b0;
    #1;
    chk("AWVALID", 64'(AWVALID), 64'd1);
    chk("AWADDR", 64'(AWADDR), 64'(a));
    chk("AWID", 64'(AWID), 64'(id));
    chk("AWLEN", 64'(AWLEN), 64'(len));
    chk("AWBURST", 64'(AWBURST), 64'(b));
    chk("AWSIZE", 64'(AWSIZE), 64'd3);
    for (int i = 0; i < stall; i++) begin
      wd_valid = 1'b1;
      tick();
      #1;
      chk("AW stall AWVALID", 64'(AWVALID), 64'd1);
      chk("AW stall AWADDR", 64'(AWADDR), 64'(a));
      chk("AW stall AWLEN", 64'(AWLEN), 64'(len));
      chk("AW stall no WVALID", 64'(WVALID), 64'd0);
    end
    wd_valid = 1'b0;
    AWREADY  = 1'b1;
    tick();
    AWREADY = 1'b0;
    #1 chk("AWVALID dropped", 64'(AWVALID), 64'd0);
  endtask

  task automatic data_phase(input int exp_beats, input bit stall);
    int beats = 0;
    int cyc   = 0;
    logic [63:0] d;
    logic [7:0]  s;
    WREADY = 1'b1;
    while (beats < exp_beats && cyc < 1000) begin
      wd_valid = !(stall && (cyc % 3 == 1));
      d = {32'hD00D_0000, 32'(beats)};
      s = 8'hFF ^ 8'(beats);
      wd_data = d;
      wd_strb = s;
      #1;
      if (wd_valid) begin
        chk("WVALID", 64'(WVALID), 64'd1);
        chk("WDATA", WDATA, d);
        chk("WSTRB", 64'(WSTRB), 64'(s));
        chk("WLAST", 64'(WLAST),
            64'(beats == exp_beats - 1));
        beats++;
      end else begin
        chk("stall WVALID", 64'(WVALID), 64'd0);
      end
      cyc++;
      tick();
    end
    chk("beat count", 64'(beats), 64'(exp_beats));
    wd_valid = 1'b1;
    #1;
    chk("post WVALID", 64'(WVALID), 64'd0);
    chk("post wd_ready", 64'(wd_ready), 64'd0);
    chk("post WLAST", 64'(WLAST), 64'd0);
    wd_valid = 1'b0;
  endtask

  task automatic b_resp(input logic [3:0] id, input logic [1:0] r);
    BVALID = 1'b1;
    BID    = id;
    BRESP  = r;
    #1 chk("BREADY", 64'(BREADY), 64'd1);
    tick();
    BVALID = 1'b0;
    #1;
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rsp_id", 64'(rsp_id), 64'(id));
    chk("rsp_resp", 64'(rsp_resp), 64'(r));
    tick();
    #1 chk("rsp_valid pulse", 64'(rsp_valid), 64'd0);
  endtask

  task automatic burst(input logic [31:0] a, input logic [3:0] id,
                       input logic [7:0] len, input logic [1:0] b);
    issue_cmd(a, id, len, b);
    addr_phase(a, id, len, b, 0);
    data_phase(int'(len) + 1, 1'b0);
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{32'h0000_1000, 4'd1, 8'd3,   2'b01, 2'b00, 1'b0, 4};
    vecs[1] = '{32'h0000_2000, 4'd5, 8'd0,   2'b01, 2'b10, 1'b0, 1};
    vecs[2] = '{32'h0000_3010, 4'd7, 8'd7,   2'b10, 2'b01, 1'b1, 8};
    vecs[3] = '{32'h0000_0040, 4'd2, 8'd255, 2'b00, 2'b11, 1'b0, 256};

    ARst      = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_id    = '0;
    cmd_len   = '0;
    cmd_burst = '0;
    wd_valid  = 1'b1;
    wd_data   = 64'hFFFF_FFFF_FFFF_FFFF;
    wd_strb   = 8'hFF;
    AWREADY   = 1'b0;
    WREADY    = 1'b1;
    BID       = '0;
    BRESP     = '0;
    BVALID    = 1'b0;

    repeat (2) tick();
    #1 chk_idle_outs("reset");
    chk("reset cmd_ready", 64'(cmd_ready), 64'd0);
    ARst     = 1'b0;
    wd_valid = 1'b0;
    tick();

    for (int v = 0; v < 4; v++) begin
      issue_cmd(vecs[v].addr, vecs[v].id, vecs[v].len, vecs[v].burst);
      addr_phase(vecs[v].addr, vecs[v].id, vecs[v].len,
                 vecs[v].burst, 0);
      data_phase(vecs[v].exp_beats, vecs[v].stall);
      chk("cmd_ready after burst", 64'(cmd_ready), 64'd1);
      b_resp(vecs[v].id, vecs[v].bresp);
      chk("BREADY drained", 64'(BREADY), 64'd0);
    end

    // AWREADY held low for 5 cycles
    issue_cmd(32'h0000_5000, 4'd9, 8'd0, 2'b01);
    addr_phase(32'h0000_5000, 4'd9, 8'd0, 2'b01, 5);
    data_phase(1, 1'b0);
    b_resp(4'd9, 2'b00);

    // MAX_OUT=2: third command blocked until a B handshake
    burst(32'h0000_6000, 4'd1, 8'd0, 2'b01);
    burst(32'h0000_6100, 4'd2, 8'd0, 2'b01);
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0000_6200;
    cmd_id    = 4'd3;
    for (int i = 0; i < 3; i++) begin
      #1 chk("blocked cmd_ready", 64'(cmd_ready), 64'd0);
      tick();
    end
    cmd_valid = 1'b0;
    BVALID = 1'b1;
    BID    = 4'd1;
    BRESP  = 2'b00;
    tick();
    BVALID = 1'b0;
    #1;
    chk("unblock rsp_id", 64'(rsp_id), 64'd1);
    chk("unblocked cmd_ready", 64'(cmd_ready), 64'd1);
    burst(32'h0000_6200, 4'd3, 8'd0, 2'b01);
    BVALID = 1'b1;
    BID    = 4'd2;
    BRESP  = 2'b01;
    tick();
    BID    = 4'd3;
    BRESP  = 2'b11;
    #1;
    chk("b2b rsp_valid 1", 64'(rsp_valid), 64'd1);
    chk("b2b rsp_id 1", 64'(rsp_id), 64'd2);
    tick();
    BVALID = 1'b0;
    #1;
    chk("b2b rsp_valid 2", 64'(rsp_valid), 64'd1);
    chk("b2b rsp_id 2", 64'(rsp_id), 64'd3);
    chk("b2b rsp_resp 2", 64'(rsp_resp), 64'd3);
    chk("b2b BREADY", 64'(BREADY), 64'd0);
    tick();

    // AW and B handshakes in the same cycle
    burst(32'h0000_7000, 4'd4, 8'd0, 2'b01);
    issue_cmd(32'h0000_7100, 4'd6, 8'd0, 2'b01);
    AWREADY = 1'b1;
    BVALID  = 1'b1;
    BID     = 4'd4;
    BRESP   = 2'b00;
    tick();
    AWREADY = 1'b0;
    BVALID  = 1'b0;
    #1;
    chk("overlap rsp_valid", 64'(rsp_valid), 64'd1);
    chk("overlap BREADY", 64'(BREADY), 64'd1);
    data_phase(1, 1'b0);
    chk("overlap cmd_ready", 64'(cmd_ready), 64'd1);
    b_resp(4'd6, 2'b00);
    chk("overlap drained", 64'(BREADY), 64'd0);

    // reset at beat 2 of 8
    issue_cmd(32'h0000_8000, 4'd8, 8'd7, 2'b01);
    addr_phase(32'h0000_8000, 4'd8, 8'd7, 2'b01, 0);
    WREADY   = 1'b1;
    wd_valid = 1'b1;
    wd_data  = 64'h1111;
    tick();
    wd_data = 64'h2222;
    ARst    = 1'b1;
    tick();
    #1 chk_idle_outs("mid reset");
    ARst = 1'b0;
    tick();
    #1;
    chk("after reset WVALID", 64'(WVALID), 64'd0);
    chk("after reset wd_ready", 64'(wd_ready), 64'd0);
    chk("after reset cmd_ready", 64'(cmd_ready), 64'd1);
    chk("after reset BREADY", 64'(BREADY), 64'd0);
    wd_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
